// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU operation per accepted request, reads the
// result back over the BR (low word) and MR (high word, multiply only) bus
// strobes, and hands {hi, lo, flags} back to the requester.
module alu_op_sequencer #(
    parameter int         DATA_W  = 16,
    parameter int         FLAG_W  = 5,
    parameter logic [2:0] OP_MPY  = 3'b010,
    parameter int         COUNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [2:0]         i_req_op,
    input  logic [DATA_W-1:0]  i_req_p,
    input  logic [DATA_W-1:0]  i_req_q,
    output logic [DATA_W-1:0]  o_alu_p,
    output logic [DATA_W-1:0]  o_alu_q,
    output logic [2:0]         o_alu_op,
    output logic               o_alu_en,
    output logic               o_c9,
    output logic               o_c10,
    input  logic [DATA_W-1:0]  i_br,
    input  logic [DATA_W-1:0]  i_mr,
    input  logic [FLAG_W-1:0]  i_flags,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [DATA_W-1:0]  o_res_lo,
    output logic [DATA_W-1:0]  o_res_hi,
    output logic [FLAG_W-1:0]  o_res_flags,
    output logic [COUNT_W-1:0] o_op_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_RD_LO = 3'd2,
        S_RD_HI = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q,     state_d;
    logic [DATA_W-1:0]   alu_p_q,     alu_p_d;
    logic [DATA_W-1:0]   alu_q_q,     alu_q_d;
    logic [2:0]          alu_op_q,    alu_op_d;
    logic [DATA_W-1:0]   res_lo_q,    res_lo_d;
    logic [DATA_W-1:0]   res_hi_q,    res_hi_d;
    logic [FLAG_W-1:0]   res_flags_q, res_flags_d;
    logic [COUNT_W-1:0]  op_count_q,  op_count_d;

    // Only the multiply opcode produces a high word on MR; anything else,
    // including unused opcodes, is treated as a single-word result.
    function automatic logic is_mpy(input logic [2:0] op);
        return (op == OP_MPY);
    endfunction

    // State and datapath registers; reset overrides everything, so an
    // operation in flight is simply abandoned.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            alu_p_q     <= '0;
            alu_q_q     <= '0;
            alu_op_q    <= 3'b000;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            res_flags_q <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            alu_p_q     <= alu_p_d;
            alu_q_q     <= alu_q_d;
            alu_op_q    <= alu_op_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
            res_flags_q <= res_flags_d;
            op_count_q  <= op_count_d;
        end
    end

    // Next-state and datapath update for the request/issue/readback sequence.
    always_comb begin
        state_d     = state_q;
        alu_p_d     = alu_p_q;
        alu_q_d     = alu_q_q;
        alu_op_d    = alu_op_q;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        res_flags_d = res_flags_q;
        op_count_d  = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    alu_p_d  = i_req_p;
                    alu_q_d  = i_req_q;
                    alu_op_d = i_req_op;
                    state_d  = S_ISSUE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ISSUE: begin
                // ALU updates BR/MR/flags on the edge closing this cycle.
                state_d = S_RD_LO;
            end
            S_RD_LO: begin
                res_lo_d    = i_br;
                res_flags_d = i_flags;
                if (is_mpy(alu_op_q)) begin
                    state_d = S_RD_HI;
                end else begin
                    res_hi_d = '0;
                    state_d  = S_DONE;
                end
            end
            S_RD_HI: begin
                res_hi_d = i_mr;
                state_d  = S_DONE;
            end
            S_DONE: begin
                // Returning to IDLE (rather than accepting here) enforces the
                // one-idle-cycle spacing between operations.
                if (i_res_ready) begin
                    op_count_d = op_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                    state_d    = S_IDLE;
                end else begin
                    state_d    = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Strobes are decoded purely from the state register, so they are
    // mutually exclusive by construction.
    assign o_req_ready = (state_q == S_IDLE);
    assign o_alu_en    = (state_q == S_ISSUE);
    assign o_c9        = (state_q == S_RD_LO);
    assign o_c10       = (state_q == S_RD_HI);
    assign o_res_valid = (state_q == S_DONE);

    assign o_alu_p     = alu_p_q;
    assign o_alu_q     = alu_q_q;
    assign o_alu_op    = alu_op_q;
    assign o_res_lo    = res_lo_q;
    assign o_res_hi    = res_hi_q;
    assign o_res_flags = res_flags_q;
    assign o_op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a behavioural ALU drives BR/MR
// only while the matching strobe is high, and results are compared against
// values computed directly from the operation's arithmetic.
module tb_alu_op_sequencer;

    localparam int         DW  = 16;
    localparam int         FW  = 5;
    localparam int         CW  = 4;
    localparam logic [2:0] MPY = 3'b010;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'b000;
    logic [DW-1:0] req_p = 16'h0000;
    logic [DW-1:0] req_q = 16'h0000;
    logic [DW-1:0] alu_p, alu_q;
    logic [2:0]    alu_op;
    logic          alu_en, c9, c10;
    logic [DW-1:0] br_bus, mr_bus;
    logic [FW-1:0] flags_bus;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_lo, res_hi;
    logic [FW-1:0] res_flags;
    logic [CW-1:0] op_count;

    int n_checks   = 0;
    int n_pass     = 0;
    int exp_count  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DATA_W (DW),
        .FLAG_W (FW),
        .OP_MPY (MPY),
        .COUNT_W(CW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_op   (req_op),
        .i_req_p    (req_p),
        .i_req_q    (req_q),
        .o_alu_p    (alu_p),
        .o_alu_q    (alu_q),
        .o_alu_op   (alu_op),
        .o_alu_en   (alu_en),
        .o_c9       (c9),
        .o_c10      (c10),
        .i_br       (br_bus),
        .i_mr       (mr_bus),
        .i_flags    (flags_bus),
        .o_res_valid(res_valid),
        .i_res_ready(res_ready),
        .o_res_lo   (res_lo),
        .o_res_hi   (res_hi),
        .o_res_flags(res_flags),
        .o_op_count (op_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Behavioural ALU: {ZF,CF,OF,NF,MF}; MR carries the product high word
    // for multiply, and unrelated data otherwise.
    function automatic void alu_eval(input logic [2:0] op, input logic [15:0] p, input logic [15:0] q,
                                     output logic [15:0] br, output logic [15:0] mr, output logic [4:0] fl);
        logic [16:0] s;
        logic [31:0] prod;
        logic cf, ov, mf;
        br = 16'h0000; mr = p ^ q; cf = 1'b0; ov = 1'b0; mf = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, p} + {1'b0, q}; br = s[15:0]; cf = s[16];
                        ov = (p[15] == q[15]) && (br[15] != p[15]); end
            3'd1: begin s = {1'b0, p} - {1'b0, q}; br = s[15:0]; cf = s[16];
                        ov = (p[15] != q[15]) && (br[15] != p[15]); end
            3'd2: begin prod = 32'(p) * 32'(q); br = prod[15:0]; mr = prod[31:16]; mf = (mr != 16'h0000); end
            3'd3: br = p & q;
            3'd4: br = p | q;
            3'd5: br = p ^ q;
            3'd6: br = ~p;
            default: br = p;
        endcase
        fl = {(br == 16'h0000), cf, ov, br[15], mf};
    endfunction

    logic [15:0] env_br = 16'h0000, env_mr = 16'h0000, junk = 16'h0000;
    logic [4:0]  env_fl = 5'h00;

    // ALU environment: results update on the edge closing the enable cycle.
    always @(posedge clk) begin : alu_env
        logic [15:0] b, m;
        logic [4:0]  f;
        junk <= 16'($urandom);
        if (alu_en) begin
            alu_eval(alu_op, alu_p, alu_q, b, m, f);
            env_br <= b;
            env_mr <= m;
            env_fl <= f;
        end
    end

    assign br_bus    = c9  ? env_br : junk;
    assign mr_bus    = c10 ? env_mr : ~junk;
    assign flags_bus = env_fl;

    // Runs one operation starting at a negedge in IDLE and ends at the negedge
    // after the result handshake. With chain set, a new request is presented
    // during DONE and must not be taken until the following IDLE cycle.
    task automatic run_op(input logic [2:0] op, input logic [15:0] p, input logic [15:0] q,
                          input int hold, input bit chain,
                          input logic [15:0] np, input logic [15:0] nq);
        logic [15:0] eb, em, ehi;
        logic [4:0]  ef;
        int lat, exp_lat;
        bit bad, mpy;
        mpy     = (op == MPY);
        alu_eval(op, p, q, eb, em, ef);
        ehi     = mpy ? em : 16'h0000;
        exp_lat = mpy ? 4 : 3;
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_p = p; req_q = q;
        res_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'($urandom); req_p = 16'($urandom); req_q = 16'($urandom);
        check_eq("alu_p", 32'(alu_p), 32'(p));
        check_eq("alu_q", 32'(alu_q), 32'(q));
        check_eq("alu_op", 32'(alu_op), 32'(op));
        bad = 1'b0; lat = 0;
        for (int k = 1; k <= 8; k++) begin
            if (alu_en != (k == 1)) bad = 1'b1;
            if (c9 != (k == 2)) bad = 1'b1;
            if (c10 != (k == 3 && mpy)) bad = 1'b1;
            if (req_ready != 1'b0) bad = 1'b1;
            if (res_valid) begin lat = k; break; end
            @(negedge clk);
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("strobes", 32'(bad), 32'd0);
        check_eq("res_lo", 32'(res_lo), 32'(eb));
        check_eq("res_hi", 32'(res_hi), 32'(ehi));
        check_eq("res_flags", 32'(res_flags), 32'(ef));
        if (hold > 0) begin
            bad = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (!res_valid || req_ready || res_lo != eb || res_hi != ehi || res_flags != ef) bad = 1'b1;
                if (32'(op_count) != 32'(exp_count)) bad = 1'b1;
            end
            check_eq("hold_stable", 32'(bad), 32'd0);
            res_ready = 1'b1;
        end
        if (chain) begin
            req_valid = 1'b1; req_op = 3'b000; req_p = np; req_q = nq;
        end
        @(negedge clk);
        exp_count = (exp_count + 1) % 16;
        check_eq("res_valid_after", 32'(res_valid), 32'd0);
        check_eq("op_count", 32'(op_count), 32'(exp_count));
        if (chain) check_eq("no_accept_in_done", 32'(alu_p), 32'(p));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_strobes", 32'({alu_en, c9, c10, res_valid}), 32'd0);
        check_eq("rst_outputs", 32'(res_lo | res_hi | alu_p | alu_q), 32'd0);
        check_eq("rst_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b000, 16'd5, 16'd7, 0, 1'b0, 16'h0, 16'h0);          // ADD
        run_op(3'b010, 16'h0100, 16'h0100, 0, 1'b0, 16'h0, 16'h0);    // MPY
        run_op(3'b001, 16'd3, 16'd5, 5, 1'b0, 16'h0, 16'h0);          // SUB with backpressure
        check_eq("sub_nf", 32'(res_flags[1]), 32'd1);
        run_op(3'b000, 16'd10, 16'd20, 0, 1'b1, 16'd30, 16'd40);      // held valid
        run_op(3'b000, 16'd30, 16'd40, 0, 1'b0, 16'h0, 16'h0);

        // Reset in the middle of an operation.
        req_valid = 1'b1; req_op = 3'b000; req_p = 16'd9; req_q = 16'd9; res_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("issue_before_rst", 32'(alu_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_strobes", 32'({alu_en, c9, c10, res_valid}), 32'd0);
        check_eq("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_count", 32'(op_count), 32'd0);
        check_eq("mid_rst_alu_p", 32'(alu_p), 32'd0);
        exp_count = 0;
        repeat (3) @(negedge clk);
        check_eq("no_partial_result", 32'(res_valid), 32'd0);
        run_op(3'b000, 16'd1, 16'd1, 0, 1'b0, 16'h0, 16'h0);

        // Counter wrap: from 1, sixteen more operations pass 15 and reach 1 again.
        for (int i = 0; i < 16; i++)
            run_op(3'b000, 16'(i), 16'd1, 0, 1'b0, 16'h0, 16'h0);

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom_range(7, 0)), 16'($urandom), 16'($urandom),
                   int'($urandom_range(3, 0)), 1'b0, 16'h0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
